// File: rtl/jt12_wrsched.sv
// Write scheduler for the JT12 FM core register port: arbitrates two requesters and
// sequences address/data strobes. Define JT12_WRSCHED_FIFO_EN to queue requester B in a 4-deep FIFO.
module jt12_wrsched #(
    parameter int WR_CYC  = 2,
    parameter int GAP_CYC = 2,
    parameter int TMO     = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic       a_part,
    input  logic [7:0] a_reg,
    input  logic [7:0] a_val,
    output logic       a_ack,
    input  logic       b_req,
    input  logic       b_part,
    input  logic [7:0] b_reg,
    input  logic [7:0] b_val,
    output logic       b_ack,
    output logic [7:0] din,
    output logic [1:0] addr,
    output logic       write,
    input  logic       busy,
    output logic       idle,
    output logic       tmo_err
);

    typedef enum logic [2:0] {IDLE, ADR, GAP, DAT, BWAIT} state_t;

    // A zero gap still needs one low cycle so the core sees a fresh rising edge.
    localparam int         GAP_N    = (GAP_CYC < 1) ? 1 : GAP_CYC;
    localparam logic [3:0] WR_LAST  = 4'(WR_CYC - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_N - 1);
    localparam logic [8:0] TMO_LIM  = 9'(TMO);

    state_t      state;
    logic [3:0]  cnt;
    logic [7:0]  tcnt;
    logic        last_b;
    logic        cur_part;
    logic [7:0]  cur_val;
    logic        b_pend;
    logic [16:0] b_head;
    logic        b_ack_nxt;
    logic        gnt_a;
    logic        gnt_b;
    logic [16:0] sel;

`ifdef JT12_WRSCHED_FIFO_EN
    logic [16:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  fill;
    logic        push;

    // b_ack high means the requester has not yet seen the previous push; skip that cycle.
    always_comb begin
        push      = b_req & (fill != 3'd4) & ~b_ack;
        b_pend    = (fill != 3'd0);
        b_head    = fifo_mem[rd_ptr];
        b_ack_nxt = push;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {b_part, b_reg, b_val};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            fill   <= 3'd0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 2'd1;
            if (gnt_b) rd_ptr <= rd_ptr + 2'd1;
            case ({push, gnt_b})
                2'b10:   fill <= fill + 3'd1;
                2'b01:   fill <= fill - 3'd1;
                default: ;
            endcase
        end
    end
`else
    always_comb begin
        b_pend    = b_req;
        b_head    = {b_part, b_reg, b_val};
        b_ack_nxt = gnt_b;
    end
`endif

    // Round-robin: B wins a tie only when A was served last.
    always_comb begin
        gnt_b = (state == IDLE) & b_pend & (~a_req | ~last_b);
        gnt_a = (state == IDLE) & a_req & ~gnt_b;
        sel   = gnt_b ? b_head : {a_part, a_reg, a_val};
    end

    always_comb begin
        idle = (state == IDLE) & ~a_req & ~b_req;
`ifdef JT12_WRSCHED_FIFO_EN
        idle = idle & (fill == 3'd0);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            tcnt     <= 8'd0;
            last_b   <= 1'b1;
            cur_part <= 1'b0;
            cur_val  <= 8'd0;
            din      <= 8'd0;
            addr     <= 2'd0;
            write    <= 1'b0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            a_ack   <= gnt_a;
            b_ack   <= b_ack_nxt;
            tmo_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_a | gnt_b) begin
                        state    <= ADR;
                        cnt      <= 4'd0;
                        last_b   <= gnt_b;
                        cur_part <= sel[16];
                        cur_val  <= sel[7:0];
                        addr     <= {sel[16], 1'b0};
                        din      <= sel[15:8];
                        write    <= 1'b1;
                    end
                end
                ADR: begin
                    if (cnt == WR_LAST) begin
                        state <= GAP;
                        cnt   <= 4'd0;
                        write <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= DAT;
                        cnt   <= 4'd0;
                        addr  <= {cur_part, 1'b1};
                        din   <= cur_val;
                        write <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DAT: begin
                    if (cnt == WR_LAST) begin
                        state <= BWAIT;
                        cnt   <= 4'd0;
                        tcnt  <= 8'd0;
                        write <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                BWAIT: begin
                    // The core may not have raised busy yet in the first cycle.
                    tcnt <= tcnt + 8'd1;
                    if (tcnt != 8'd0) begin
                        if (!busy) begin
                            state <= IDLE;
                        end else if (({1'b0, tcnt} + 9'd1) >= TMO_LIM) begin
                            tmo_err <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt12_wrsched.sv
// Scoreboard bench for jt12_wrsched: stimulus queues expected port accesses and acks,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_jt12_wrsched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a_req = 1'b0, a_part = 1'b0, b_req = 1'b0, b_part = 1'b0, busy = 1'b0;
    logic [7:0] a_reg = 8'h00, a_val = 8'h00, b_reg = 8'h00, b_val = 8'h00;
    logic       a_ack, b_ack, write, idle, tmo_err;
    logic [7:0] din;
    logic [1:0] addr;

    logic       a_req2 = 1'b0, busy2 = 1'b0;
    logic       a_ack2, b_ack2, write2, idle2, tmo2;
    logic [7:0] din2;
    logic [1:0] addr2;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
        int         gap;
    } port_t;

    port_t pq[$];
    bit    aq[$];

    always #5 clk = ~clk;

    jt12_wrsched #(.WR_CYC(2), .GAP_CYC(2), .TMO(255)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_part(a_part), .a_reg(a_reg), .a_val(a_val), .a_ack(a_ack),
        .b_req(b_req), .b_part(b_part), .b_reg(b_reg), .b_val(b_val), .b_ack(b_ack),
        .din(din), .addr(addr), .write(write), .busy(busy), .idle(idle), .tmo_err(tmo_err)
    );

    jt12_wrsched #(.WR_CYC(2), .GAP_CYC(2), .TMO(16)) dut_t (
        .clk(clk), .rst(rst),
        .a_req(a_req2), .a_part(a_part), .a_reg(a_reg), .a_val(a_val), .a_ack(a_ack2),
        .b_req(1'b0), .b_part(1'b0), .b_reg(8'h00), .b_val(8'h00), .b_ack(b_ack2),
        .din(din2), .addr(addr2), .write(write2), .busy(busy2), .idle(idle2), .tmo_err(tmo2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_acc(input bit p, input logic [7:0] r, input logic [7:0] v);
        port_t e;
        e.a = {p, 1'b0}; e.d = r; e.gap = -1; pq.push_back(e);
        e.a = {p, 1'b1}; e.d = v; e.gap = 2;  pq.push_back(e);
    endtask

    task automatic wait_ack(input bit want_b, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (want_b ? b_ack : a_ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (idle) break;
            tick();
        end
        chk("idle_timeout", idle, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
    endtask

    // Monitor: reconstructs each write-strobe burst and the ack pulses.
    port_t      e;
    logic       pw = 1'b0, pa = 1'b0, pb = 1'b0;
    int         hi_len = 0, lo_len = 0, st_gap = 0;
    logic [1:0] cur_a;
    logic [7:0] cur_d;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                pw = 1'b0; pa = 1'b0; pb = 1'b0; hi_len = 0; lo_len = 0;
            end else begin
                if (write) begin
                    if (!pw) begin
                        cur_a = addr; cur_d = din; hi_len = 1; st_gap = lo_len;
                    end else begin
                        hi_len++;
                        chk("port_stable", {addr, din}, {cur_a, cur_d});
                    end
                end else if (pw) begin
                    if (pq.size() == 0) begin
                        chk("unexpected_access", {cur_a, cur_d}, 0);
                    end else begin
                        e = pq.pop_front();
                        chk("acc_addr", cur_a, e.a);
                        chk("acc_din", cur_d, e.d);
                        chk("acc_len", hi_len, 2);
                        if (e.gap >= 0) chk("acc_gap", st_gap, e.gap);
                    end
                    lo_len = 1;
                end else begin
                    lo_len++;
                end
                pw = write;
                if (a_ack || b_ack) begin
                    chk("dual_ack", a_ack & b_ack, 0);
                    chk("ack_pulse", (a_ack & pa) | (b_ack & pb), 0);
                    if (aq.size() == 0) chk("unexpected_ack", {a_ack, b_ack}, 0);
                    else chk("ack_order", b_ack, aq.pop_front());
                end
                pa = a_ack; pb = b_ack;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;

        // Reset state
        tick(); tick();
        chk("rst_write", write, 0);
        chk("rst_din", din, 0);
        chk("rst_addr", addr, 0);
        chk("rst_ack", {a_ack, b_ack}, 0);
        chk("rst_tmo", tmo_err, 0);
        chk("rst_idle", idle, 1);
        rst = 1'b1;

        // Single A access, checked cycle by cycle to IDLE
        a_part = 1'b0; a_reg = 8'h28; a_val = 8'hF1;
        exp_acc(1'b0, 8'h28, 8'hF1); aq.push_back(1'b0);
        a_req = 1'b1;
        wait_ack(1'b0, 10, ok);
        chk("a_ack_seen", ok, 1);
        a_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("bwait_not_idle", idle, 0);
        tick();
        chk("back_to_idle", idle, 1);

        // Round-robin with both requesting continuously from reset
        do_reset();
        a_part = 1'b0; a_reg = 8'h30; a_val = 8'h11;
        b_part = 1'b1; b_reg = 8'h40; b_val = 8'h22;
        for (int i = 0; i < 2; i++) begin
            exp_acc(1'b0, 8'h30, 8'h11); aq.push_back(1'b0);
            exp_acc(1'b1, 8'h40, 8'h22); aq.push_back(1'b1);
        end
        a_req = 1'b1; b_req = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (a_ack || b_ack) n++;
            if (n == 4) break;
        end
        a_req = 1'b0; b_req = 1'b0;
        chk("rr_ack_count", n, 4);
        wait_idle(40);

        // B on part 1 with busy held; a following A access must wait for busy to fall
        b_part = 1'b1; b_reg = 8'hA4; b_val = 8'h22;
        exp_acc(1'b1, 8'hA4, 8'h22); aq.push_back(1'b1);
        a_part = 1'b0; a_reg = 8'h55; a_val = 8'h66;
        exp_acc(1'b0, 8'h55, 8'h66); aq.push_back(1'b0);
        busy = 1'b1; b_req = 1'b1;
        wait_ack(1'b1, 10, ok);
        chk("b_ack_seen", ok, 1);
        b_req = 1'b0; a_req = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (a_ack) n++;
        end
        chk("blocked_by_busy", n, 0);
        busy = 1'b0;
        wait_ack(1'b0, 10, ok);
        chk("a_after_busy", ok, 1);
        a_req = 1'b0;
        wait_idle(40);

        // Timeout on the TMO=16 instance
        busy2 = 1'b1; a_req2 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_ack2) begin ok = 1'b1; break; end
        end
        chk("t_ack_seen", ok, 1);
        a_req2 = 1'b0;
        for (int i = 1; i <= 23; i++) begin
            tick();
            if (i == 21) chk("tmo_early", tmo2, 0);
            if (i == 22) begin
                chk("tmo_pulse", tmo2, 1);
                chk("tmo_idle", idle2, 1);
            end
            if (i == 23) chk("tmo_single", tmo2, 0);
        end
        busy2 = 1'b0;

        // Reset asserted during DAT
        a_part = 1'b0; a_reg = 8'h77; a_val = 8'h88;
        e.a = 2'b00; e.d = 8'h77; e.gap = -1; pq.push_back(e); aq.push_back(1'b0);
        a_req = 1'b1;
        wait_ack(1'b0, 10, ok);
        chk("r_ack_seen", ok, 1);
        a_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("dat_write", write, 1);
        chk("dat_addr", addr, 2'b01);
        #1 rst = 1'b0;
        #1 chk("rst_async_write", write, 0);
        chk("rst_mid_din", din, 0);
        tick(); tick(); tick();
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_ack || b_ack) n++;
        end
        chk("post_rst_acks", n, 0);
        chk("post_rst_idle", idle, 1);

`ifdef JT12_WRSCHED_FIFO_EN
        // FIFO: A occupies the port with busy high while B fills the queue
        busy = 1'b1;
        a_part = 1'b0; a_reg = 8'h10; a_val = 8'h01;
        exp_acc(1'b0, 8'h10, 8'h01); aq.push_back(1'b0);
        for (int i = 0; i < 5; i++) begin
            exp_acc(1'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i));
            aq.push_back(1'b1);
        end
        a_req = 1'b1;
        wait_ack(1'b0, 10, ok);
        chk("f_a_ack", ok, 1);
        a_req = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            b_part = 1'(i); b_reg = 8'hB0 + 8'(i); b_val = 8'hC0 + 8'(i);
            b_req = 1'b1;
            wait_ack(1'b1, 8, ok);
            if (ok) n++;
        end
        chk("fifo_acks", n, 4);
        chk("fifo_full_stall", ok, 0);
        busy = 1'b0;
        wait_ack(1'b1, 100, ok);
        chk("fifo_fifth_ack", ok, 1);
        b_req = 1'b0;
        wait_idle(200);
`endif

        tick(); tick();
        chk("ports_drained", pq.size(), 0);
        chk("acks_drained", aq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
